// File: rtl/ulight_fifo_button_pio_in.sv
// ulight_fifo_button_pio_in: Avalon-MM input PIO with a 2-flop synchronizer,
// sticky edge capture (write-1-to-clear) and a masked level interrupt.
module ulight_fifo_button_pio_in #(
    parameter int          WIDTH      = 5,
    parameter int          EDGE_TYPE  = 0,
    parameter logic [31:0] RESET_MASK = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    logic [WIDTH-1:0] sync1_q, sync2_q, sync_d_q, edge_q, edge_d, mask_q, mask_d, det, wd;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr, unused_wd;

    always_comb begin
        wd = writedata[WIDTH-1:0];
        wr = chipselect & ~write_n;
        det = EDGE_TYPE == 1 ? ~sync2_q & sync_d_q :
              EDGE_TYPE == 2 ? sync2_q ^ sync_d_q : sync2_q & ~sync_d_q;
        mask_d = wr && address == 2'd2 ? wd : mask_q;
        // a new edge wins over a clear of the same bit
        edge_d = (edge_q & ~(wr && address == 2'd3 ? wd : '0)) | det;
        readdata_d = address == 2'd0 ? 32'(sync2_q) :
                     address == 2'd2 ? 32'(mask_q) :
                     address == 2'd3 ? 32'(edge_q) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            sync_d_q   <= '0;
            edge_q     <= '0;
            mask_q     <= RESET_MASK[WIDTH-1:0];
            readdata_q <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            sync_d_q   <= sync2_q;
            edge_q     <= edge_d;
            mask_q     <= mask_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata  = readdata_q;
    assign irq       = |(edge_q & mask_q);
    assign unused_wd = ^writedata;
endmodule

// File: doc/ulight_fifo_button_pio_in.md
Name: ulight_fifo_button_pio_in

Overview:
Avalon-MM slave input PIO, the read-side counterpart of the LED output PIO in the ulight_fifo system. It samples an external WIDTH-bit input port through a 2-flop synchronizer and exposes the synchronized level. It latches edges into a sticky edge-capture register and raises a level interrupt to the Nios/host through a per-bit interrupt mask. It sits on the same system interconnect as the output PIOs, at a 4-word address window.

Parameters:
WIDTH, 5, width of in_port and of all internal registers (1..32)
EDGE_TYPE, 0, edge to capture: 0 = rising, 1 = falling, 2 = any
RESET_MASK, 0, reset value of the interrupt mask register (WIDTH bits)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
address  input  2  word address in slave window
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data; only [WIDTH-1:0] used
in_port  input  WIDTH  asynchronous external inputs (buttons/status)
readdata  output  32  registered read data, upper bits zero
irq  output  1  level interrupt, active high

Behaviour:
- Reset: clk and reset_n, reset asynchronous, active-low. All state returns to its reset value immediately on assertion and stays there while reset_n is low:
  - sync1, sync2, sync_d = 0
  - edge_capture = 0
  - irq_mask = RESET_MASK
  - readdata = 0
  - irq = 0 unless forced by the mask and capture terms below (it is 0 after reset because edge_capture = 0)
- Synchronizer: sync1 <= in_port; sync2 <= sync1; sync_d <= sync2, every clock.
- Edge detect, combinational from sync2/sync_d:
  - rising = sync2 & ~sync_d
  - falling = ~sync2 & sync_d
  - any = sync2 ^ sync_d
  - EDGE_TYPE selects which one is used.
- Timing for an in_port change sampled at clk edge k:
  - sync2 updates at k+1
  - edge_capture bit sets at k+2
  - irq asserts during the cycle after k+2
- Register map:
  - 0, data: R = sync2, zero-extended. Writes ignored.
  - 1, direction: R = 0. Writes ignored.
  - 2, irq_mask: R/W [WIDTH-1:0]. Written on chipselect & ~write_n & address==2.
  - 3, edge_capture: R = sticky bits. Write-1-to-clear: bit i cleared when chipselect & ~write_n & address==3 & writedata[i].
- Edge capture rules:
  - Bit set on detected edge.
  - Bit holds until cleared.
  - Simultaneous set and clear of the same bit in the same cycle: set wins (bit stays 1).
  - Clear of other bits is unaffected.
- Read:
  - readdata <= mux(address) every clock; 1-cycle read latency (interconnect readLatency = 1).
  - chipselect not required for read data; reads have no side effects.
- irq = |(edge_capture & irq_mask), combinational from registers, glitch-free.
  - Mask change takes effect the cycle after the write.
  - Masking does not clear capture.
- Reset release with in_port already high: sync chain fills from 0, so one rising edge is captured (EDGE_TYPE 0/2). Software must clear edge_capture after boot.
- Pulses shorter than one clk period may be missed; no requirement to capture them.
- Writes to unused bits [31:WIDTH] are ignored; reads return 0 there.

Test Plan:
- Reset with in_port=5'h00, RESET_MASK=0 -> readdata=0 at all addresses, irq=0, edge_capture=0.
- EDGE_TYPE=0: write mask 5'h1F, drive in_port 5'h00->5'h04 at edge k -> edge_capture=5'h04 from k+2, irq=1. Then read addr 0 -> 5'h04 one cycle after address presented.
- Write 32'h0000_0004 to addr 3 -> edge_capture=0, irq=0 next cycle. Repeat with writedata=0 -> capture unchanged.
- Clear bit 1 in the same cycle that bit 1's rising edge is detected -> bit 1 remains set, irq stays high.
- Mask=5'h01, edge on bit 3 only -> edge_capture=5'h08, irq=0. Write mask 5'h08 -> irq=1 next cycle.
- EDGE_TYPE=2, toggle bit 0 high then low with captures cleared between -> both transitions captured. Assert reset_n=0 mid-test -> all registers zero asynchronously, irq drops immediately.
